// File: rtl/parallel_xor_pipe.sv
// Two-stage valid/ready pipeline that XORs two operands lane-wise and post-processes
// the result as pass, running checksum, parity reduction or delta against the previous beat.
module parallel_xor_pipe #(
  parameter int S = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [(2**S)-1:0] in1,
  input  logic [(2**S)-1:0] in2,
  input  logic [1:0]        mode,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [(2**S)-1:0] out,
  output logic              parity
);

  localparam int W = 2**S;

  logic         a_valid;
  logic [W-1:0] a_x;
  logic [1:0]   a_mode;
  logic [W-1:0] acc;
  logic [W-1:0] hist;
  logic         in_fire;
  logic         b_adv;
  logic [W-1:0] acc_base;
  logic [W-1:0] hist_base;
  logic [W-1:0] acc_new;
  logic [W-1:0] result;

  assign in_ready = !reset && (!a_valid || !out_valid || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign b_adv    = a_valid && (!out_valid || out_ready);

  // A clear on the same edge as an advance acts before the beat is applied
  always_comb begin
    acc_base  = clear ? '0 : acc;
    hist_base = clear ? '0 : hist;
    acc_new   = acc_base ^ a_x;
    result    = a_x;
    case (a_mode)
      2'b01: result = acc_new;
      2'b10: begin
        result    = '0;
        result[0] = ^a_x;
      end
      2'b11: result = a_x ^ hist_base;
      default: result = a_x;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid <= 1'b0;
      a_x     <= '0;
      a_mode  <= 2'b00;
    end else if (in_fire) begin
      a_valid <= 1'b1;
      a_x     <= in1 ^ in2;
      a_mode  <= mode;
    end else if (b_adv) begin
      a_valid <= 1'b0;
    end
  end

  // Mode-specific state updates below take precedence over the clear assignment
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out       <= '0;
      parity    <= 1'b0;
      acc       <= '0;
      hist      <= '0;
    end else begin
      if (clear) begin
        acc  <= '0;
        hist <= '0;
      end
      if (b_adv) begin
        out       <= result;
        parity    <= ^result;
        out_valid <= 1'b1;
        if (a_mode == 2'b01) acc  <= acc_new;
        if (a_mode == 2'b11) hist <= a_x;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/parallel_xor_pipe.md
Name: parallel_xor_pipe

Overview:
- Registered, flow-controlled successor to the combinational parallel XOR bank.
- Per beat, takes two 2**S-bit operands and forms the lane-wise XOR.
- Post-processes the XOR in one of four modes: pass, accumulate (running checksum), reduce-parity, delta versus the previous beat.
- Two-stage valid/ready pipeline; sits between datapath producers and consumers where back-pressure must be honoured.

Parameters:
- S, 3, log2 of lane count; data width W = 2**S, with S >= 0.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat offered
- in_ready  output  1  block can accept a beat this cycle
- in1  input  W  operand A
- in2  input  W  operand B
- mode  input  2  per-beat mode, captured with the operands: 00 pass, 01 accumulate, 10 parity, 11 delta
- clear  input  1  one-cycle pulse; clears accumulator and delta history
- out_valid  output  1  result beat available
- out_ready  input  1  consumer accepts the result
- out  output  W  result
- parity  output  1  XOR-reduction of the current out bus; always valid alongside out

Behaviour:
- Reset (clk edge with reset=1):
  - stage-A valid=0, out_valid=0, out=0, parity=0, accumulator=0, delta history=0.
  - in_ready is forced to 0 while reset is high.
  - Reset mid-operation drops all in-flight beats; no partial result is emitted.
- Handshake:
  - A transfer occurs when valid && ready on the same edge.
  - out_valid, out and parity stay stable while out_valid=1 and out_ready=0.
  - in_ready = !reset && (!a_valid || (!out_valid || out_ready)). This is combinational from out_ready; no combinational path exists from in_valid to in_ready.
- Stage A:
  - On input transfer, registers x = in1 ^ in2 (lane-wise) and mode; sets a_valid=1.
  - When stage A advances into stage B with no new input, a_valid clears.
- Stage B advances when a_valid && (!out_valid || out_ready). On advance it computes, per captured mode:
  - 00: out = x.
  - 01: acc_next = acc ^ x; out = acc_next; acc <= acc_next.
  - 10: out = {W-1 zeros, ^x}.
  - 11: out = x ^ hist; hist <= x.
  - hist and acc update only in their own mode.
  - If out_valid=1 is consumed and stage A is not valid, out_valid clears.
- Latency: 2 cycles from input transfer to out_valid with no back-pressure. Full throughput is 1 beat/cycle.
- Stall: out_ready=0 with both stages full gives in_ready=0. No beat is lost or duplicated; order is preserved.
- clear:
  - Takes effect on the edge where it is sampled high, independent of valid/ready.
  - If it coincides with a stage-B advance in mode 01, acc <= x (clear first, then apply). In mode 11, out = x and hist <= x.
  - clear does not alter a result already held on out.
  - reset has priority over clear.
- S = 0: W = 1; parity mode output equals x; all rules otherwise unchanged.
- parity is registered together with out (parity = ^out), never computed from unregistered data.

Test Plan:
- Pass mode, S=3: in1=8'hF0, in2=8'h3C, out_ready=1 -> two cycles later out_valid=1, out=8'hCC, parity=0.
- Accumulate: beats x=8'h01, 8'h02, 8'h04 back-to-back -> outputs 8'h01, 8'h03, 8'h07 on consecutive cycles. Pulse clear, then x=8'h10 -> 8'h10. Also check clear coincident with an advance in mode 01 gives acc=x.
- Parity/delta: mode 10 with x=8'h07 -> out=8'h01, parity=1. Mode 11 with x=8'hAA then 8'hFF -> 8'hAA, then 8'h55.
- Back-pressure: stream 5 mixed beats with out_ready toggling 1,0,0,1,... -> in_ready drops when both stages are full, out is stable during stalls, all 5 results arrive in order, and acc is correct.
- Reset mid-stream:
  - Assert reset with both stages full -> next cycle out_valid=0, out=0, in_ready=0.
  - After release, accumulate x=8'h05 -> 8'h05, proving acc was cleared.
- Parameter sweep S=0 and S=5: random operands in all modes checked against a reference model for 1000 beats with random out_ready.
